pfb_demux: RTL

Input commutator for the analysis polyphase filterbank. Takes a continuous complex ADC sample stream (up to one sample per clock) and sends it to the PFB filter input port. Each sample is tagged with a channel index that counts down from NUM_CHANNELS-1 to 0 and wraps. A small FIFO absorbs bursts, and output valids are spaced to the filter's minimum input interval. Overflow is flagged and resynchronises the commutator.

---
 rtl/pfb_demux_pkg.sv | 13 +
 rtl/pfb_demux_fifo.sv | 67 ++++++
 rtl/pfb_demux.sv | 114 +++++++++++
 3 files changed

// File: rtl/pfb_demux_pkg.sv
// Shared types for the PFB input commutator.
package pfb_demux_pkg;

  // Width of one I or Q component in the sample word.
  localparam int PFB_DATA_WIDTH = 12;

  // One complex sample as stored in the commutator FIFO.
  typedef struct packed {
    logic signed [PFB_DATA_WIDTH-1:0] i;
    logic signed [PFB_DATA_WIDTH-1:0] q;
  } pfb_iq_sample_t;

endpackage

// File: rtl/pfb_demux_fifo.sv
// Synchronous sample FIFO. Full already accounts for a same-cycle pop, so a
// push into a full FIFO that is draining this cycle is accepted.
module pfb_demux_fifo
  import pfb_demux_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  pfb_iq_sample_t data_i,
  output pfb_iq_sample_t data_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int AW = $clog2(DEPTH);

  pfb_iq_sample_t mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic [AW:0]    count_d;
  logic           push_ok;
  logic           pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH)) && !pop_i;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; flush empties without touching storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Sample storage; contents are only ever read behind a valid pointer.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pfb_demux.sv
// Input commutator for the analysis PFB: buffers ADC samples, paces them to
// the filter's minimum input interval and tags each with a down-counting
// channel index. An overflow flushes the buffer and restarts channel alignment.
module pfb_demux
  import pfb_demux_pkg::*;
#(
  parameter int NUM_CHANNELS        = 32,
  parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
  parameter int DATA_WIDTH          = PFB_DATA_WIDTH,
  parameter int FIFO_DEPTH          = 16,
  parameter int OUTPUT_SPACING      = 2
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           Input_valid,
  input  logic signed [DATA_WIDTH-1:0]   Input_i,
  input  logic signed [DATA_WIDTH-1:0]   Input_q,
  output logic                           Output_valid,
  output logic [CHANNEL_INDEX_WIDTH-1:0] Output_index,
  output logic signed [DATA_WIDTH-1:0]   Output_i,
  output logic signed [DATA_WIDTH-1:0]   Output_q,
  output logic                           Error_overflow
);

  localparam int SPW = (OUTPUT_SPACING > 1) ? $clog2(OUTPUT_SPACING) : 1;
  localparam logic [SPW-1:0] SPACE_RELOAD = SPW'(OUTPUT_SPACING - 1);
  localparam logic [CHANNEL_INDEX_WIDTH-1:0] CHAN_TOP = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);

  pfb_iq_sample_t push_word;
  pfb_iq_sample_t head_word;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic           overflow;

  logic [CHANNEL_INDEX_WIDTH-1:0] chan_q, chan_d;
  logic [SPW-1:0]                 space_q, space_d;
  logic                           valid_q, valid_d;
  logic [CHANNEL_INDEX_WIDTH-1:0] index_q, index_d;
  logic signed [DATA_WIDTH-1:0]   out_i_q, out_i_d;
  logic signed [DATA_WIDTH-1:0]   out_q_q, out_q_d;
  logic                           ovf_q, ovf_d;

  assign push_word.i = Input_i;
  assign push_word.q = Input_q;
  assign pop         = !fifo_empty && (space_q == '0);
  assign overflow    = Input_valid && fifo_full;

  pfb_demux_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .flush_i (overflow),
    .push_i  (Input_valid),
    .pop_i   (pop),
    .data_i  (push_word),
    .data_o  (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pop/pacing/overflow decisions; full already excludes a same-cycle pop.
  always_comb begin
    chan_d  = chan_q;
    space_d = space_q;
    valid_d = 1'b0;
    index_d = index_q;
    out_i_d = out_i_q;
    out_q_d = out_q_q;
    ovf_d   = overflow;
    if (overflow) begin
      chan_d  = CHAN_TOP;
      space_d = '0;
    end else if (pop) begin
      valid_d = 1'b1;
      index_d = chan_q;
      out_i_d = head_word.i;
      out_q_d = head_word.q;
      chan_d  = chan_q - CHANNEL_INDEX_WIDTH'(1);
      space_d = SPACE_RELOAD;
    end else if (space_q != '0) begin
      space_d = space_q - SPW'(1);
    end
  end

  // Counters, output register and overflow pulse.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      chan_q  <= CHAN_TOP;
      space_q <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      out_i_q <= '0;
      out_q_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      chan_q  <= chan_d;
      space_q <= space_d;
      valid_q <= valid_d;
      index_q <= index_d;
      out_i_q <= out_i_d;
      out_q_q <= out_q_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Output_valid   = valid_q;
  assign Output_index   = index_q;
  assign Output_i       = out_i_q;
  assign Output_q       = out_q_q;
  assign Error_overflow = ovf_q;

endmodule
